// File: rtl/lisa_qspi_arbiter_n.sv
// -----------------------------------------------------------------------------
// lisa_qspi_arbiter_n
// Arbitrates N request ports (index 0 = debug port) onto one QSPI controller.
// Client 0 can optionally preempt the round-robin among the other clients.
// A client may cancel before its first beat. A per-transfer watchdog aborts a
// transfer that has stalled and flags the owning client.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   c_addr/c_wdata/c_wstrb/c_valid/c_xfer_len/c_ce_ctrl
//                         : packed per-client request fields (client i at slice i)
//   c_rdata/c_ready/c_xfer_done/c_timeout
//                         : per-client responses, driven only for the owner
//   grant                 : one-hot owner, 0 when idle
//   dbg_custom_spi_cmd, dbg_cmd_quad_write
//                         : client 0 command overrides, forwarded only while
//                           client 0 owns the bus
//   addr/wdata/wstrb/valid/xfer_len/ce_ctrl/custom_spi_cmd/cmd_quad_write/abort
//                         : controller request side
//   rdata/ready/xfer_done : controller response side
// -----------------------------------------------------------------------------
module lisa_qspi_arbiter_n #(
    parameter int N_CLIENTS    = 4,
    parameter int CHIP_SELECTS = 2,
    parameter int PRIO_CLIENT0 = 1,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CLIENTS*24-1:0]          c_addr,
    input  logic [N_CLIENTS*16-1:0]          c_wdata,
    input  logic [N_CLIENTS*2-1:0]           c_wstrb,
    input  logic [N_CLIENTS-1:0]             c_valid,
    input  logic [N_CLIENTS*4-1:0]           c_xfer_len,
    input  logic [N_CLIENTS*CHIP_SELECTS-1:0] c_ce_ctrl,
    output logic [N_CLIENTS*16-1:0]          c_rdata,
    output logic [N_CLIENTS-1:0]             c_ready,
    output logic [N_CLIENTS-1:0]             c_xfer_done,
    output logic [N_CLIENTS-1:0]             c_timeout,
    output logic [N_CLIENTS-1:0]             grant,
    input  logic                             dbg_custom_spi_cmd,
    input  logic [7:0]                       dbg_cmd_quad_write,
    output logic [23:0]                      addr,
    output logic [15:0]                      wdata,
    output logic [1:0]                       wstrb,
    output logic                             valid,
    output logic [3:0]                       xfer_len,
    output logic [CHIP_SELECTS-1:0]          ce_ctrl,
    output logic                             custom_spi_cmd,
    output logic [7:0]                       cmd_quad_write,
    output logic                             abort,
    input  logic [15:0]                      rdata,
    input  logic                             ready,
    input  logic                             xfer_done
);

    localparam int SEL_W = $clog2(N_CLIENTS);
    localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam bit PRIO0 = (PRIO_CLIENT0 != 0);
    localparam logic [SEL_W-1:0] RR_RESET = PRIO0 ? SEL_W'(1) : SEL_W'(0);
    localparam logic [TMR_W-1:0] TMR_LAST = WD_EN ? TMR_W'(TIMEOUT_CYC - 1) : TMR_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BURST = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    // One-hot encoding of a client index.
    function automatic logic [N_CLIENTS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_CLIENTS-1:0] one;
        one = {{(N_CLIENTS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [N_CLIENTS-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]       timer_q, timer_d;

    logic                   win_found_s;
    logic                   win_rr_s;
    logic [SEL_W-1:0]       win_idx_s;
    logic [SEL_W-1:0]       rr_next_s;
    logic                   wd_fire_s;

    // Arbitration: client 0 preempts when enabled, else scan from rr_ptr.
    always_comb begin : p_arb
        int idx;
        int nxt;
        idx         = 0;
        nxt         = 0;
        win_found_s = 1'b0;
        win_rr_s    = 1'b0;
        win_idx_s   = SEL_W'(0);
        rr_next_s   = rr_ptr_q;
        if (PRIO0 && c_valid[0]) begin
            win_found_s = 1'b1;
            win_idx_s   = SEL_W'(0);
        end else begin
            for (int off = 0; off < N_CLIENTS; off++) begin
                idx = int'(rr_ptr_q) + off;
                if (idx >= N_CLIENTS) begin
                    idx = idx - N_CLIENTS;
                end else begin
                    idx = idx;
                end
                if (!win_found_s && c_valid[idx] && !(PRIO0 && (idx == 0))) begin
                    win_found_s = 1'b1;
                    win_rr_s    = 1'b1;
                    win_idx_s   = SEL_W'(idx);
                end else begin
                    win_found_s = win_found_s;
                end
            end
            // Pointer moves to the next eligible index after the winner.
            nxt = int'(win_idx_s) + 1;
            if (nxt >= N_CLIENTS) begin
                nxt = PRIO0 ? 1 : 0;
            end else begin
                nxt = nxt;
            end
            rr_next_s = SEL_W'(nxt);
        end
    end

    // Watchdog expires in the last counted cycle unless the controller responds.
    always_comb begin
        wd_fire_s = WD_EN && (timer_q == TMR_LAST) && !ready && !xfer_done;
    end

    // Next-state logic of the ownership FSM and watchdog timer.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        timer_d  = timer_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = TMR_W'(0);
                if (win_found_s) begin
                    sel_d   = win_idx_s;
                    grant_d = onehot(win_idx_s);
                    state_d = ST_GRANT;
                    if (win_rr_s) begin
                        rr_ptr_d = rr_next_s;
                    end else begin
                        rr_ptr_d = rr_ptr_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (xfer_done) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (ready) begin
                    state_d = ST_BURST;
                    timer_d = TMR_W'(0);
                end else if (!c_valid[sel_q]) begin
                    // Client withdrew before the first beat: release silently.
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (wd_fire_s) begin
                    state_d = ST_ABORT;
                end else begin
                    timer_d = WD_EN ? timer_q + TMR_W'(1) : TMR_W'(0);
                end
            end
            ST_BURST: begin
                if (xfer_done) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (ready) begin
                    timer_d = TMR_W'(0);
                end else if (wd_fire_s) begin
                    state_d = ST_ABORT;
                end else begin
                    timer_d = WD_EN ? timer_q + TMR_W'(1) : TMR_W'(0);
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                grant_d = '0;
                timer_d = TMR_W'(0);
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                timer_d = TMR_W'(0);
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_W'(0);
            grant_q  <= '0;
            rr_ptr_q <= RR_RESET;
            timer_q  <= TMR_W'(0);
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= timer_d;
        end
    end

    // Request mux toward the controller and response routing to the owner.
    always_comb begin
        addr           = c_addr[int'(sel_q)*24 +: 24];
        wdata          = c_wdata[int'(sel_q)*16 +: 16];
        wstrb          = c_wstrb[int'(sel_q)*2 +: 2];
        xfer_len       = c_xfer_len[int'(sel_q)*4 +: 4];
        ce_ctrl        = c_ce_ctrl[int'(sel_q)*CHIP_SELECTS +: CHIP_SELECTS];
        valid          = (state_q == ST_GRANT) && c_valid[sel_q];
        abort          = (state_q == ST_ABORT);
        grant          = grant_q;
        custom_spi_cmd = grant_q[0] ? dbg_custom_spi_cmd : 1'b0;
        cmd_quad_write = grant_q[0] ? dbg_cmd_quad_write : 8'h00;
        c_rdata        = '0;
        c_ready        = '0;
        c_xfer_done    = '0;
        c_timeout      = '0;
        if (grant_q != '0) begin
            c_rdata[int'(sel_q)*16 +: 16] = rdata;
            c_ready[sel_q]                = ready;
            c_xfer_done[sel_q]            = xfer_done || (state_q == ST_ABORT);
            c_timeout[sel_q]              = (state_q == ST_ABORT);
        end else begin
            c_rdata = '0;
        end
    end

endmodule

// File: tb/tb_lisa_qspi_arbiter_n.sv
module tb_lisa_qspi_arbiter_n;

    localparam int N  = 4;
    localparam int CS = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*24-1:0]   c_addr;
    logic [N*16-1:0]   c_wdata;
    logic [N*2-1:0]    c_wstrb;
    logic [N-1:0]      c_valid;
    logic [N*4-1:0]    c_xfer_len;
    logic [N*CS-1:0]   c_ce_ctrl;
    logic [N*16-1:0]   c_rdata;
    logic [N-1:0]      c_ready;
    logic [N-1:0]      c_xfer_done;
    logic [N-1:0]      c_timeout;
    logic [N-1:0]      grant;
    logic              dbg_custom_spi_cmd;
    logic [7:0]        dbg_cmd_quad_write;
    logic [23:0]       addr;
    logic [15:0]       wdata;
    logic [1:0]        wstrb;
    logic              valid;
    logic [3:0]        xfer_len;
    logic [CS-1:0]     ce_ctrl;
    logic              custom_spi_cmd;
    logic [7:0]        cmd_quad_write;
    logic              abort;
    logic [15:0]       rdata;
    logic              ready;
    logic              xfer_done;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    lisa_qspi_arbiter_n #(
        .N_CLIENTS(N), .CHIP_SELECTS(CS), .PRIO_CLIENT0(1), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb), .c_valid(c_valid),
        .c_xfer_len(c_xfer_len), .c_ce_ctrl(c_ce_ctrl),
        .c_rdata(c_rdata), .c_ready(c_ready), .c_xfer_done(c_xfer_done),
        .c_timeout(c_timeout), .grant(grant),
        .dbg_custom_spi_cmd(dbg_custom_spi_cmd), .dbg_cmd_quad_write(dbg_cmd_quad_write),
        .addr(addr), .wdata(wdata), .wstrb(wstrb), .valid(valid), .xfer_len(xfer_len),
        .ce_ctrl(ce_ctrl), .custom_spi_cmd(custom_spi_cmd), .cmd_quad_write(cmd_quad_write),
        .abort(abort), .rdata(rdata), .ready(ready), .xfer_done(xfer_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    function automatic logic [23:0] addr_of(input int i);
        return 24'hA00000 + 24'(i * 4369);
    endfunction

    // Wait for a grant, then score it against the oldest expected owner.
    task automatic wait_grant(output int who);
        int lat;
        bit got;
        got = 1'b0;
        lat = 0;
        who = -1;
        for (int c = 1; c <= 20; c++) begin
            if (!got) begin
                @(posedge clk); #1;
                if (grant != '0) begin
                    got = 1'b1;
                    lat = c;
                end
            end
        end
        if (!got) begin
            chk("grant_wait", 64'd0, 64'd1);
        end else if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            who = exp_q.pop_front();
            chk("grant", 64'(grant), 64'(oh(who)));
            chk("grant_lat", 64'(lat), 64'd1);
            chk("valid_at_grant", 64'(valid), 64'd1);
            chk("addr_mux", 64'(addr), 64'(addr_of(who)));
            chk("len_mux", 64'(xfer_len), 64'(who + 4));
            chk("custom_cmd", 64'(custom_spi_cmd), (who == 0) ? 64'd1 : 64'd0);
            chk("quad_cmd", 64'(cmd_quad_write), (who == 0) ? 64'h32 : 64'h0);
        end
    endtask

    // One transfer: ready every second cycle, xfer_done with the last beat.
    task automatic run_xfer(input int nbeats, input logic [N-1:0] add_mid);
        int who;
        int cur;
        int nrdy;
        logic [63:0] exp_rd;
        wait_grant(who);
        cur  = (who < 0) ? 0 : who;
        nrdy = 0;
        for (int b = 0; b < nbeats; b++) begin
            @(posedge clk); #1;
            ready = 1'b0; xfer_done = 1'b0;
            if (b == 1) c_valid = c_valid | add_mid;
            chk((b == 0) ? "valid_pre_ready" : "valid_gated", 64'(valid), (b == 0) ? 64'd1 : 64'd0);
            chk("grant_hold", 64'(grant), 64'(oh(cur)));
            @(posedge clk); #1;
            ready = 1'b1;
            xfer_done = (b == nbeats - 1);
            rdata = 16'($urandom);
            #1;
            if (c_ready == oh(cur)) nrdy++;
            exp_rd = 64'(rdata) << (16 * cur);
            chk("c_rdata", 64'(c_rdata), exp_rd);
            if (b == nbeats - 1) chk("c_xfer_done", 64'(c_xfer_done), 64'(oh(cur)));
        end
        @(posedge clk); #1;
        ready = 1'b0; xfer_done = 1'b0;
        chk("grant_drop", 64'(grant), 64'd0);
        chk("ready_count", 64'(nrdy), 64'(nbeats));
        chk("quad_idle", 64'(cmd_quad_write), 64'h0);
    endtask

    // Watchdog scenario for client 1; abort expected at cycle abort_k after grant.
    task automatic wd_run(input int rdy_k, input int done_k, input int abort_k, input int last_k);
        int who;
        c_valid = 4'b0010;
        exp_q.push_back(1);
        wait_grant(who);
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            ready     = (k == rdy_k);
            xfer_done = (k == done_k);
            if (k == last_k) c_valid = 4'b0000;
            #1;
            chk("abort", 64'(abort), (k == abort_k) ? 64'd1 : 64'd0);
            if (k == abort_k) begin
                chk("c_timeout", 64'(c_timeout), 64'(4'b0010));
                chk("abort_done", 64'(c_xfer_done), 64'(4'b0010));
                chk("abort_valid", 64'(valid), 64'd0);
            end else if (k == done_k) begin
                chk("wd_done", 64'(c_xfer_done), 64'(4'b0010));
            end else begin
                chk("no_timeout", 64'(c_timeout), 64'd0);
            end
        end
        @(posedge clk); #1;
        ready = 1'b0; xfer_done = 1'b0;
        chk("wd_grant_drop", 64'(grant), 64'd0);
        chk("wd_abort_low", 64'(abort), 64'd0);
        chk("wd_timeout_low", 64'(c_timeout), 64'd0);
    endtask

    initial begin
        int who;
        rst_n = 1'b0;
        c_valid = '0;
        ready = 1'b0; xfer_done = 1'b0; rdata = 16'h0;
        dbg_custom_spi_cmd = 1'b1;
        dbg_cmd_quad_write = 8'h32;
        for (int i = 0; i < N; i++) begin
            c_addr[i*24 +: 24]    = addr_of(i);
            c_wdata[i*16 +: 16]   = 16'(16'h5500 + i);
            c_wstrb[i*2 +: 2]     = 2'b11;
            c_xfer_len[i*4 +: 4]  = 4'(i + 4);
            c_ce_ctrl[i*CS +: CS] = CS'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_abort", 64'(abort), 64'd0);
        chk("rst_cresp", 64'({c_ready, c_xfer_done, c_timeout}), 64'd0);
        chk("rst_custom", 64'(custom_spi_cmd), 64'd0);
        rst_n = 1'b1;

        // Held requests from clients 1..3: round robin starting at 1.
        c_valid = 4'b1110;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(1);
        repeat (4) run_xfer(2, 4'b0000);

        // Client 2 with 4 beats; client 0 requests mid-burst and preempts 3.
        c_valid = 4'b1100;
        exp_q.push_back(2);
        run_xfer(4, 4'b0001);
        c_valid = 4'b1001;
        exp_q.push_back(0);
        run_xfer(2, 4'b0000);
        c_valid = 4'b1000;
        exp_q.push_back(3);
        run_xfer(1, 4'b0000);

        // Clients 2 and 3 alternate.
        c_valid = 4'b1100;
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(2);
        repeat (3) run_xfer(1, 4'b0000);

        // Watchdog: plain timeout, xfer_done in the timeout cycle, ready restarts the count.
        wd_run(0, 0, 8, 8);
        wd_run(0, 7, -1, 7);
        wd_run(5, 0, 14, 14);

        // Client 2 cancels before its first beat; pending client 3 follows.
        c_valid = 4'b1100;
        exp_q.push_back(2);
        wait_grant(who);
        c_valid = 4'b1000;
        @(posedge clk); #1;
        chk("cancel_grant", 64'(grant), 64'd0);
        chk("cancel_no_done", 64'(c_xfer_done), 64'd0);
        exp_q.push_back(3);
        run_xfer(1, 4'b0000);

        // Reset in the middle of a burst.
        c_valid = 4'b0010;
        exp_q.push_back(1);
        wait_grant(who);
        @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        chk("burst_valid", 64'(valid), 64'd0);
        chk("burst_grant", 64'(grant), 64'(4'b0010));
        rst_n = 1'b0;
        c_valid = 4'b1010;
        @(posedge clk); #1;
        chk("midrst_grant", 64'(grant), 64'd0);
        chk("midrst_valid", 64'(valid), 64'd0);
        rst_n = 1'b1;
        exp_q.push_back(1);
        run_xfer(1, 4'b0000);
        c_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("end_idle", 64'(grant), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
